// File: rtl/timer_irq_ctrl_if.sv
// Peripheral bus and interrupt handshake between the pipeline and timer_irq_ctrl.
// master: pipeline / bus side.  slave: the timer controller.
interface timer_irq_ctrl_if;
  logic        peri_cre_i;
  logic        peri_cwe_i;
  logic [31:0] peri_addr_i;
  logic [31:0] peri_wdata_i;
  logic [31:0] peri_rdata_o;
  logic        irq_o;
  logic        irq_ack_i;

  modport master (
    output peri_cre_i, peri_cwe_i, peri_addr_i, peri_wdata_i, irq_ack_i,
    input  peri_rdata_o, irq_o
  );

  modport slave (
    input  peri_cre_i, peri_cwe_i, peri_addr_i, peri_wdata_i, irq_ack_i,
    output peri_rdata_o, irq_o
  );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped timer with TH (reload), TL (counter), TCON (control/status),
// an optional 8-bit prescaler and a level interrupt held until acknowledged.
// Optional feature macro: TIMER_PRESCALER_EN (PRESC register and pcnt logic).
// Without it PRESC reads zero, writes to it are ignored, and every enabled
// cycle is a tick.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input logic             clk,
  input logic             rst,
  timer_irq_ctrl_if.slave bus
);

  localparam logic [31:0] ADDR_TH    = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] ADDR_TL    = BASE_ADDR + 32'h0000_0004;
  localparam logic [31:0] ADDR_TCON  = BASE_ADDR + 32'h0000_0008;
`ifdef TIMER_PRESCALER_EN
  localparam logic [31:0] ADDR_PRESC = BASE_ADDR + 32'h0000_0018;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } irq_state_e;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        status_q, status_d;
  logic        ovr_q, ovr_d;
  logic        irq_q, irq_d;
  irq_state_e  state_q, state_d;

`ifdef TIMER_PRESCALER_EN
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        wr_presc_s;
`endif

  logic        wr_th_s, wr_tl_s, wr_tcon_s;
  logic        tick_s, ovf_s;
  logic        clr_status_s, clr_ovr_s;
  logic [31:0] rdata_s;

  assign wr_th_s   = bus.peri_cwe_i && (bus.peri_addr_i == ADDR_TH);
  assign wr_tl_s   = bus.peri_cwe_i && (bus.peri_addr_i == ADDR_TL);
  assign wr_tcon_s = bus.peri_cwe_i && (bus.peri_addr_i == ADDR_TCON);

  // status/ovr are cleared by writing 0 to their bit; writing 1 leaves them alone
  assign clr_status_s = wr_tcon_s && !bus.peri_wdata_i[2];
  assign clr_ovr_s    = wr_tcon_s && !bus.peri_wdata_i[3];

`ifdef TIMER_PRESCALER_EN
  assign wr_presc_s = bus.peri_cwe_i && (bus.peri_addr_i == ADDR_PRESC);
  assign tick_s     = en_q && (pcnt_q == presc_q);
`else
  assign tick_s     = en_q;
`endif

  assign ovf_s = tick_s && (tl_q == 32'hFFFF_FFFF);

`ifdef TIMER_PRESCALER_EN
  // Prescaler: count up to PRESC, wrap on tick, park at zero while disabled
  always_comb begin
    pcnt_d  = pcnt_q;
    presc_d = presc_q;
    if (!en_q) begin
      pcnt_d = 8'd0;
    end else if (tick_s) begin
      pcnt_d = 8'd0;
    end else begin
      pcnt_d = pcnt_q + 8'd1;
    end
    if (wr_presc_s) begin
      presc_d = bus.peri_wdata_i[7:0];
    end else begin
      presc_d = presc_q;
    end
  end
`endif

  // Counter, reload and control/status next-state; bus writes to TL beat the tick
  always_comb begin
    th_d     = th_q;
    tl_d     = tl_q;
    en_d     = en_q;
    ie_d     = ie_q;
    status_d = status_q;
    ovr_d    = ovr_q;

    if (wr_th_s) begin
      th_d = bus.peri_wdata_i;
    end else begin
      th_d = th_q;
    end

    if (wr_tl_s) begin
      tl_d = bus.peri_wdata_i;
    end else if (ovf_s) begin
      tl_d = th_q;
    end else if (tick_s) begin
      tl_d = tl_q + 32'd1;
    end else begin
      tl_d = tl_q;
    end

    if (wr_tcon_s) begin
      en_d = bus.peri_wdata_i[0];
      ie_d = bus.peri_wdata_i[1];
    end else begin
      en_d = en_q;
      ie_d = ie_q;
    end

    // An overflow always wins over a software clear of status; when both
    // coincide the overflow is treated as the first one, so ovr is untouched.
    if (ovf_s) begin
      status_d = 1'b1;
      if (clr_status_s) begin
        ovr_d = ovr_q;
      end else if (status_q) begin
        ovr_d = 1'b1;
      end else if (clr_ovr_s) begin
        ovr_d = 1'b0;
      end else begin
        ovr_d = ovr_q;
      end
    end else begin
      status_d = clr_status_s ? 1'b0 : status_q;
      ovr_d    = clr_ovr_s ? 1'b0 : ovr_q;
    end
  end

  // Interrupt handshake FSM; irq_o is the registered image of the PEND state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (status_q && ie_q) begin
          state_d = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (bus.irq_ack_i) begin
          state_d = SERV;
        end else if (!ie_q) begin
          state_d = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      SERV: begin
        if (!status_q) begin
          state_d = IDLE;
        end else begin
          state_d = SERV;
        end
      end
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == PEND);
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      th_q     <= 32'h0000_0000;
      tl_q     <= 32'h0000_0000;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      status_q <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
      state_q  <= IDLE;
`ifdef TIMER_PRESCALER_EN
      presc_q  <= 8'd0;
      pcnt_q   <= 8'd0;
`endif
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      status_q <= status_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
      state_q  <= state_d;
`ifdef TIMER_PRESCALER_EN
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
`endif
    end
  end

  // Combinational read mux; zero during reset, without read enable, or unmapped
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (!rst && bus.peri_cre_i) begin
      case (bus.peri_addr_i)
        ADDR_TH:    rdata_s = th_q;
        ADDR_TL:    rdata_s = tl_q;
        ADDR_TCON:  rdata_s = {28'h000_0000, ovr_q, status_q, ie_q, en_q};
`ifdef TIMER_PRESCALER_EN
        ADDR_PRESC: rdata_s = {24'h00_0000, presc_q};
`endif
        default:    rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.peri_rdata_o = rdata_s;
  assign bus.irq_o        = irq_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Testbench for timer_irq_ctrl: directed scenarios with fixed expectations,
// then randomized bus traffic checked against a behavioural model.
module tb_timer_irq_ctrl;
  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TH  = BASE + 32'h0;
  localparam logic [31:0] A_TL  = BASE + 32'h4;
  localparam logic [31:0] A_TC  = BASE + 32'h8;
  localparam logic [31:0] A_PR  = BASE + 32'h18;
`ifdef TIMER_PRESCALER_EN
  localparam logic PRESC_EN = 1'b1;
  localparam int   PSTEP    = 3;
`else
  localparam logic PRESC_EN = 1'b0;
  localparam int   PSTEP    = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_irq_ctrl_if bus();
  timer_irq_ctrl #(.BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_th, m_tl;
  logic [7:0]  m_presc, m_pcnt;
  logic        m_en, m_ie, m_st, m_ovr;
  logic        m_irq, m_serv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_th = 32'h0; m_tl = 32'h0; m_presc = 8'h0; m_pcnt = 8'h0;
    m_en = 1'b0; m_ie = 1'b0; m_st = 1'b0; m_ovr = 1'b0;
    m_irq = 1'b0; m_serv = 1'b0;
  endtask

  // one clock edge of the timer rules, applied to the inputs present at the edge
  task automatic model_step();
    logic [31:0] a, w;
    logic we, ack, tick, ovf, wtc, cs, co, n_irq, n_serv;
    a = bus.peri_addr_i; w = bus.peri_wdata_i; we = bus.peri_cwe_i; ack = bus.irq_ack_i;
    tick = m_en && (!PRESC_EN || (m_pcnt == m_presc));
    ovf  = tick && (m_tl == 32'hFFFF_FFFF);
    wtc  = we && (a == A_TC);
    cs   = wtc && !w[2];
    co   = wtc && !w[3];
    n_irq = m_irq; n_serv = m_serv;
    if (m_serv) begin
      if (!m_st) n_serv = 1'b0;
    end else if (m_irq) begin
      if (ack) begin n_irq = 1'b0; n_serv = 1'b1; end
      else if (!m_ie) n_irq = 1'b0;
    end else if (m_st && m_ie) begin
      n_irq = 1'b1;
    end
    if (PRESC_EN) m_pcnt = (!m_en || tick) ? 8'd0 : m_pcnt + 8'd1;
    if (tick) m_tl = ovf ? m_th : m_tl + 32'd1;
    if (we && a == A_TH) m_th = w;
    if (we && a == A_TL) m_tl = w;
    if (PRESC_EN && we && a == A_PR) m_presc = w[7:0];
    if (ovf && cs) begin
      m_st = 1'b1;
    end else if (ovf) begin
      if (m_st) m_ovr = 1'b1;
      else if (co) m_ovr = 1'b0;
      m_st = 1'b1;
    end else begin
      if (cs) m_st = 1'b0;
      if (co) m_ovr = 1'b0;
    end
    if (wtc) begin m_en = w[0]; m_ie = w[1]; end
    m_irq = n_irq; m_serv = n_serv;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic cre);
    if (rst || !cre) return 32'h0;
    case (a)
      A_TH:    return m_th;
      A_TL:    return m_tl;
      A_TC:    return {28'h0, m_ovr, m_st, m_ie, m_en};
      A_PR:    return PRESC_EN ? {24'h0, m_presc} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("irq_o", {31'h0, bus.irq_o}, {31'h0, m_irq});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.peri_cwe_i = 1'b1; bus.peri_addr_i = a; bus.peri_wdata_i = d;
    cycle();
    bus.peri_cwe_i = 1'b0;
  endtask

  task automatic rdc(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.peri_cre_i = 1'b1; bus.peri_addr_i = a;
    #1;
    check(tag, bus.peri_rdata_o, exp);
    bus.peri_cre_i = 1'b0;
  endtask

  task automatic wait_irq();
    for (int k = 0; k < 40 && !m_irq; k++) cycle();
    check("irq_wait", {31'h0, bus.irq_o}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs [6];
    addrs[0] = A_TH; addrs[1] = A_TL; addrs[2] = A_TC; addrs[3] = A_PR;
    addrs[4] = BASE + 32'hC; addrs[5] = 32'h0000_0004;

    // reset state
    rst = 1'b1;
    bus.peri_cre_i = 1'b0; bus.peri_cwe_i = 1'b0; bus.peri_addr_i = 32'h0;
    bus.peri_wdata_i = 32'h0; bus.irq_ack_i = 1'b0;
    model_reset();
    #12;
    rdc("rd_in_reset", A_TC, 32'h0);
    check("irq_in_reset", {31'h0, bus.irq_o}, 32'h0);
    rst = 1'b0;
    rdc("th_rst", A_TH, 32'h0);
    rdc("tl_rst", A_TL, 32'h0);
    rdc("tcon_rst", A_TC, 32'h0);
    rdc("presc_rst", A_PR, 32'h0);

    // overflow and interrupt
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_PR, 32'h0);
    wr(A_TC, 32'h3);
    cycle(); rdc("tl_e1", A_TL, 32'hFFFF_FFFD);
    cycle(); rdc("tl_e2", A_TL, 32'hFFFF_FFFE);
    cycle(); rdc("tl_e3", A_TL, 32'hFFFF_FFFF);
    cycle(); rdc("tl_e4", A_TL, 32'hFFFF_FFFC); rdc("tcon_e4", A_TC, 32'h7);
    check("irq_e4", {31'h0, bus.irq_o}, 32'h0);
    cycle(); check("irq_e5", {31'h0, bus.irq_o}, 32'h1);

    // ack and clear
    bus.irq_ack_i = 1'b1; cycle(); bus.irq_ack_i = 1'b0;
    check("irq_after_ack", {31'h0, bus.irq_o}, 32'h0);
    wr(A_TC, 32'h3); rdc("tcon_clr", A_TC, 32'h3);
    cycle(); rdc("tcon_ovf2", A_TC, 32'h7);
    check("irq_ovf2", {31'h0, bus.irq_o}, 32'h0);
    cycle(); check("irq_rise2", {31'h0, bus.irq_o}, 32'h1);

    // overrun
    repeat (3) cycle();
    rdc("tcon_overrun", A_TC, 32'hF);
    wr(A_TC, 32'h3); rdc("tcon_overrun_clr", A_TC, 32'h3);

    // collisions
    wr(A_TL, 32'h10); rdc("tl_wr_on_tick", A_TL, 32'h10);
    wr(A_TL, 32'hFFFF_FFFF);
    cycle(); rdc("tcon_ovf3", A_TC, 32'h7);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3); rdc("tcon_clr_vs_ovf", A_TC, 32'h7);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h7); rdc("tcon_ovrclr_vs_ovf", A_TC, 32'hF);
    wait_irq();
    wr(A_TC, 32'hD); rdc("tcon_ie_drop", A_TC, 32'hD);
    cycle(); check("irq_ie_drop", {31'h0, bus.irq_o}, 32'h0);

    // prescaler
    wr(A_TC, 32'h0);
    wr(A_PR, 32'h2);
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      repeat (PSTEP) cycle();
      rdc("tl_presc", A_TL, k);
    end

    // async reset mid-operation with irq asserted
    wr(A_TC, 32'h0);
    wr(A_PR, 32'h0);
    wr(A_TH, 32'h0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h3);
    wait_irq();
    #2 rst = 1'b1;
    #1;
    check("irq_async_rst", {31'h0, bus.irq_o}, 32'h0);
    rdc("rd_during_rst", A_TL, 32'h0);
    model_reset();
    #1 rst = 1'b0;
    rdc("tl_after_rst", A_TL, 32'h0);
    rdc("tcon_after_rst", A_TC, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      int op;
      logic [31:0] w;
      op = $urandom_range(0, 11);
      w  = $urandom;
      bus.peri_cwe_i = 1'b0;
      bus.irq_ack_i  = ($urandom_range(0, 4) == 0);
      case (op)
        0: begin bus.peri_cwe_i = 1'b1; bus.peri_addr_i = A_TH;
                 bus.peri_wdata_i = 32'hFFFF_FFF0 + $urandom_range(0, 15); end
        1: begin bus.peri_cwe_i = 1'b1; bus.peri_addr_i = A_TL;
                 bus.peri_wdata_i = 32'hFFFF_FFF8 + $urandom_range(0, 7); end
        2, 3: begin w[0] = ($urandom_range(0, 4) != 0);
                 bus.peri_cwe_i = 1'b1; bus.peri_addr_i = A_TC; bus.peri_wdata_i = w; end
        4: begin bus.peri_cwe_i = 1'b1; bus.peri_addr_i = A_PR;
                 bus.peri_wdata_i = $urandom_range(0, 3); end
        5: begin bus.peri_cwe_i = 1'b1; bus.peri_addr_i = BASE + 32'h10;
                 bus.peri_wdata_i = w; end
        default: bus.peri_cwe_i = 1'b0;
      endcase
      cycle();
      bus.peri_cwe_i = 1'b0;
      bus.irq_ack_i  = 1'b0;
      bus.peri_addr_i = addrs[$urandom_range(0, 5)];
      bus.peri_cre_i  = ($urandom_range(0, 5) != 0);
      #1;
      check("rand_read", bus.peri_rdata_o, m_read(bus.peri_addr_i, bus.peri_cre_i));
      bus.peri_cre_i = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Memory-mapped timer controller with an interrupt handshake, sitting on the peripheral bus beside the LED, DIGITAL and SYSTICK registers. It owns the TH/TL/TCON timer registers and a prescaler, and sequences TL counting, reload and overflow. It drives a level interrupt request into the pipeline's exception logic and holds it until the pipeline acknowledges.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: base of the register window. TH is at +0x0, TL at +0x4, TCON at +0x8, PRESC at +0x18.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `peri_cre_i`  in  1: read enable.
- `peri_cwe_i`  in  1: write enable.
- `peri_addr_i`  in  32: byte address, full 32-bit compare.
- `peri_wdata_i`  in  32: write data.
- `peri_rdata_o`  out  32: read data, combinational.
- `irq_o`  out  1: interrupt request to the pipeline, registered.
- `irq_ack_i`  in  1: one-cycle pulse, pipeline has taken the interrupt.

## Operation
- **Registers**
  - TH: 32-bit reload value.
  - TL: 32-bit counter.
  - PRESC: 8-bit prescale value; reads zero-extended.
  - TCON readback: {28'b0, ovr, status, ie, en}.
- **TCON write rules**
  - en and ie are plain read/write bits.
  - status and ovr are software-clear-only: write 0 clears, write 1 has no effect.
- **Register writes:** a write occurs on the edge where peri_cwe_i=1 and the address matches. Other addresses are ignored.
- **Reads:**
  - peri_rdata_o = 0 while rst=1, while peri_cre_i=0, or for an unmapped address.
  - Otherwise it returns the addressed register.
- **Prescaler:** 8-bit pcnt.
  - While en=1: if pcnt==PRESC, a tick occurs and pcnt<=0; else pcnt<=pcnt+1.
  - While en=0: pcnt holds at 0.
- **Tick:**
  - If TL != 32'hFFFF_FFFF, TL<=TL+1.
  - Else TL<=TH, an overflow event. status<=1 if it was 0; if status was already 1, ovr<=1.
  - status is set regardless of ie.
- **IRQ FSM**, states IDLE, PEND, SERV:
  - IDLE -> PEND when status=1 and ie=1.
  - PEND: irq_o=1. On irq_ack_i=1 -> SERV. If ie=0 (and no ack that cycle) -> IDLE.
  - SERV: irq_o=0. When status=0 -> IDLE. ie is ignored in SERV.
  - irq_ack_i is ignored outside PEND.
- **Simultaneous events**
  - Bus write to TL on a tick edge: the write wins and the increment/reload is lost. pcnt still resets.
  - Software clear of status on the same edge as an overflow: the overflow wins. status stays 1 and ovr is unchanged.
  - Software clear of ovr on the same edge an overflow would set it: ovr ends at 1.
  - Write to TCON.en=0 on a tick edge: the tick still completes. Counting stops from the next edge.
  - Write to PRESC: takes effect on the next compare. pcnt is not reset.

## Timing
- **Reset:** asynchronous. TH, TL, TCON, PRESC and pcnt go to 0, the FSM goes to IDLE, irq_o=0, peri_rdata_o=0.
- **Reset mid-operation:** aborts any count or pending interrupt immediately. No ack is expected afterwards.
- **Enable latency:** TCON write at edge 0 with en=1 and PRESC=0 gives the first TL increment at edge 1.
- **Interrupt latency:** overflow at edge k makes status visible after k. irq_o rises after edge k+1 and falls after the edge sampling irq_ack_i=1.
- **Read latency:** zero-latency combinational. A write is visible to a read in the following cycle.

## Configuration
- `TIMER_PRESCALER_EN`
  - Defined: PRESC register and pcnt exist as described.
  - Undefined: PRESC reads 0, writes are ignored, no pcnt logic. A tick occurs on every cycle with en=1.

## Test plan
- **Overflow and interrupt:** PRESC=0, TH=TL=32'hFFFF_FFFC, TCON=3 at edge 0 -> TL reads FFFF_FFFD/FFFE/FFFF after edges 1/2/3. After edge 4: TL=FFFF_FFFC and TCON=4'b0111. irq_o=1 after edge 5.
- **Ack and clear:** from the previous state, pulse irq_ack_i -> irq_o=0 next cycle and FSM in SERV. Write TCON=3 -> status=0, FSM returns to IDLE. No new irq_o until the next overflow 4 ticks later.
- **Overrun:** leave status uncleared across a second overflow -> TCON reads 4'b1111. Writing TCON=3 -> reads 4'b0011.
- **Prescaler:** PRESC=2, TL=0, en=1 -> TL increments on every third edge: values 1, 2, 3 after edges 3, 6, 9. With the macro undefined, the same test gives 1, 2, 3 after edges 1, 2, 3.
- **Collisions:** TL write of 32'h10 on a tick edge -> TL=32'h10. Clearing status on an overflow edge -> status=1 and ovr unchanged. Dropping ie in PEND -> irq_o=0 next cycle.
- **Async reset:** assert rst mid-count with irq_o=1 -> irq_o, TL and TCON go to 0 without waiting for a clock edge. Reads return 0 while rst=1.
